// File: rtl/hdmi_i2c_pkg.sv
// hdmi_i2c_pkg: shared state encoding and framing constants for the HDMI I2C write engine.
package hdmi_i2c_pkg;

    typedef enum logic [2:0] {IDLE, START, BIT, ACKBIT, STOP, DONE} state_t;

    localparam int START_QTRS     = 2;
    localparam int BIT_QTRS       = 4;
    localparam int STOP_QTRS      = 3;
    localparam int BYTES_PER_XFER = 3;

endpackage

// File: rtl/hdmi_i2c_qtr_tick.sv
// hdmi_i2c_qtr_tick: registered one-cycle tick every QTR_DIV clk cycles while run is high.
module hdmi_i2c_qtr_tick #(
    parameter int QTR_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    logic [7:0] cnt;
    logic       wrap;

    assign wrap = cnt == 8'(QTR_DIV - 1);

    always_ff @(posedge clk) begin
        if (!reset || !run) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            cnt  <= wrap ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule

// File: rtl/hdmi_i2c_write_engine.sv
// hdmi_i2c_write_engine: 3-byte I2C master write (START, 3x(8 bits + ACK), STOP).
// Define I2C_ABORT_ON_NACK_EN to jump to STOP on the first NACK.
module hdmi_i2c_write_engine
    import hdmi_i2c_pkg::*;
#(
    parameter int QTR_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] I2C_DATA,
    input  logic        enable,
    output logic        I2C_SCL,
    output logic        I2C_SDA_OE,
    input  logic        I2C_SDA_IN,
    output logic        ACK,
    output logic        END
);

    state_t      state;
    logic [1:0]  qtr;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] shreg;
    logic        nack;
    logic        tick;
    logic        run;
    logic        last_byte;

    assign run = state inside {START, BIT, ACKBIT, STOP};

`ifdef I2C_ABORT_ON_NACK_EN
    assign last_byte = (byte_cnt == 2'(BYTES_PER_XFER - 1)) || nack;
`else
    assign last_byte = byte_cnt == 2'(BYTES_PER_XFER - 1);
`endif

    hdmi_i2c_qtr_tick #(.QTR_DIV(QTR_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .tick (tick)
    );

    // Outputs are registered: each tick loads the levels of the quarter being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            qtr        <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            nack       <= 1'b0;
            I2C_SCL    <= 1'b1;
            I2C_SDA_OE <= 1'b0;
            ACK        <= 1'b0;
            END        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    I2C_SCL    <= 1'b1;
                    I2C_SDA_OE <= enable;
                    END        <= 1'b0;
                    if (enable) begin
                        state    <= START;
                        qtr      <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        shreg    <= I2C_DATA;
                        nack     <= 1'b0;
                    end
                end
                START: if (tick) begin
                    if (qtr == 2'(START_QTRS - 1)) begin
                        state      <= BIT;
                        qtr        <= '0;
                        I2C_SDA_OE <= ~shreg[23];
                    end else begin
                        qtr     <= qtr + 2'd1;
                        I2C_SCL <= 1'b0;
                    end
                end
                BIT: if (tick) begin
                    qtr     <= qtr + 2'd1;
                    I2C_SCL <= qtr == 2'd1 || qtr == 2'd2;
                    if (qtr == 2'(BIT_QTRS - 1)) begin
                        bit_cnt    <= bit_cnt + 3'd1;
                        shreg      <= {shreg[22:0], 1'b0};
                        state      <= bit_cnt == 3'd7 ? ACKBIT : BIT;
                        I2C_SDA_OE <= bit_cnt == 3'd7 ? 1'b0 : ~shreg[22];
                    end
                end
                ACKBIT: if (tick) begin
                    qtr     <= qtr + 2'd1;
                    I2C_SCL <= qtr == 2'd1 || qtr == 2'd2;
                    if (qtr == 2'd2)
                        nack <= nack | I2C_SDA_IN;
                    if (qtr == 2'(BIT_QTRS - 1)) begin
                        state      <= last_byte ? STOP : BIT;
                        byte_cnt   <= byte_cnt + 2'd1;
                        I2C_SDA_OE <= last_byte ? 1'b1 : ~shreg[23];
                    end
                end
                STOP: if (tick) begin
                    qtr <= qtr + 2'd1;
                    if (qtr == 2'd0)
                        I2C_SCL <= 1'b1;
                    if (qtr == 2'd1)
                        I2C_SDA_OE <= 1'b0;
                    if (qtr == 2'(STOP_QTRS - 1)) begin
                        state <= DONE;
                        qtr   <= '0;
                        END   <= 1'b1;
                        ACK   <= nack;
                    end
                end
                DONE: if (!enable) begin
                    state <= IDLE;
                    END   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_i2c_write_engine.sv
// tb_hdmi_i2c_write_engine: directed checks of framing, ACK handling, reset and timing.
module tb_hdmi_i2c_write_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] I2C_DATA;
    logic        enable;
    logic        I2C_SCL, I2C_SDA_OE, ACK, END;
    logic        I2C_SDA_IN = 1'b1;
    logic [23:0] data4;
    logic        en4;
    logic        sda4_in = 1'b0;
    logic        scl4, oe4, ack4, end4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0, n, stop0, nack_byte, h, l;
    int rise_cnt = 0;
    int stop_cnt = 0;
    logic prev_scl = 1'b1;
    logic prev_oe = 1'b0;
    logic bits [0:31];
    bit ok;

    hdmi_i2c_write_engine #(.QTR_DIV(1)) dut (
        .clk(clk), .reset(reset), .I2C_DATA(I2C_DATA), .enable(enable),
        .I2C_SCL(I2C_SCL), .I2C_SDA_OE(I2C_SDA_OE), .I2C_SDA_IN(I2C_SDA_IN),
        .ACK(ACK), .END(END)
    );

    hdmi_i2c_write_engine #(.QTR_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .I2C_DATA(data4), .enable(en4),
        .I2C_SCL(scl4), .I2C_SDA_OE(oe4), .I2C_SDA_IN(sda4_in),
        .ACK(ack4), .END(end4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Bus monitor and slave model: START/STOP detection, bit capture on SCL rise, ACK slot drive.
    always @(negedge clk) begin
        if (I2C_SCL && prev_scl && I2C_SDA_OE && !prev_oe) rise_cnt = 0;
        if (I2C_SCL && prev_scl && !I2C_SDA_OE && prev_oe) stop_cnt++;
        if (I2C_SCL && !prev_scl) begin
            if (rise_cnt < 32) bits[rise_cnt] = !I2C_SDA_OE;
            I2C_SDA_IN = (rise_cnt % 9 == 8) ? (rise_cnt / 9 == nack_byte) : 1'b1;
            rise_cnt++;
        end
        prev_scl = I2C_SCL;
        prev_oe  = I2C_SDA_OE;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input int b);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[7-i] = bits[b*9+i];
        return v;
    endfunction

    task automatic start_xfer(input logic [23:0] d);
        @(negedge clk);
        I2C_DATA = d;
        enable = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
    endtask

    task automatic wait_end(input bit sel, output int cycles);
        cycles = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (sel ? end4 : END) begin
                cycles = cyc - t0;
                break;
            end
        end
    endtask

    task automatic wait_scl4(input logic v, output bit found);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (scl4 == v) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic drop_enable;
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; en4 = 1'b0;
        I2C_DATA = '0; data4 = '0; nack_byte = 3;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", I2C_SCL, 1);
        chk("rst_oe", I2C_SDA_OE, 0);
        chk("rst_end", END, 0);
        chk("rst_ack", ACK, 0);
        @(negedge clk) reset = 1'b1;

        // All bytes acknowledged
        stop0 = stop_cnt;
        start_xfer(24'h729803);
        wait_end(1'b0, n);
        chk("t1_end_cyc", n, 114);
        chk("t1_ack", ACK, 0);
        chk("t1_rises", rise_cnt, 28);
        chk("t1_byte0", get_byte(0), 8'h72);
        chk("t1_byte1", get_byte(1), 8'h98);
        chk("t1_byte2", get_byte(2), 8'h03);
        chk("t1_ackslot_rel", bits[8], 1);
        chk("t1_stop", stop_cnt - stop0, 1);
        repeat (3) @(posedge clk);
        #1 chk("t1_end_held", END, 1);
        drop_enable();
        chk("t1_end_drop", END, 0);

        // Slave NACKs the byte-1 ACK slot
        nack_byte = 1;
        start_xfer(24'h123456);
        wait_end(1'b0, n);
`ifdef I2C_ABORT_ON_NACK_EN
        chk("t2_end_cyc", n, 78);
        chk("t2_rises", rise_cnt, 19);
`else
        chk("t2_end_cyc", n, 114);
        chk("t2_rises", rise_cnt, 28);
        chk("t2_byte2", get_byte(2), 8'h56);
`endif
        chk("t2_ack", ACK, 1);
        chk("t2_byte0", get_byte(0), 8'h12);
        drop_enable();
        chk("t2_end_drop", END, 0);

        // Reset pulse during bit 10, then restart
        nack_byte = 3;
        stop0 = stop_cnt;
        start_xfer(24'h729803);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (rise_cnt == 10 && !I2C_SCL) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t4_reach_bit10", ok, 1);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        chk("t4_rst_scl", I2C_SCL, 1);
        chk("t4_rst_oe", I2C_SDA_OE, 0);
        chk("t4_rst_end", END, 0);
        chk("t4_no_stop", stop_cnt - stop0, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        chk("t4_start_scl", I2C_SCL, 1);
        chk("t4_start_oe", I2C_SDA_OE, 1);
        wait_end(1'b0, n);
        chk("t4_end_cyc", n, 114);
        chk("t4_ack", ACK, 0);
        drop_enable();

        // Enable dropped at bit 5, data changed after latch
        start_xfer(24'hA55AC3);
        @(negedge clk) I2C_DATA = 24'h000000;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (rise_cnt == 5) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t5_reach_bit5", ok, 1);
        @(negedge clk) enable = 1'b0;
        wait_end(1'b0, n);
        chk("t5_end_cyc", n, 114);
        chk("t5_byte0", get_byte(0), 8'hA5);
        chk("t5_byte1", get_byte(1), 8'h5A);
        chk("t5_byte2", get_byte(2), 8'hC3);
        @(posedge clk);
        #1;
        chk("t5_end_pulse", END, 0);
        chk("t5_idle_scl", I2C_SCL, 1);
        chk("t5_idle_oe", I2C_SDA_OE, 0);

        // QTR_DIV=4 timing
        @(negedge clk);
        data4 = 24'h729803;
        en4 = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        wait_scl4(1'b0, ok);
        chk("t6_scl_low", ok, 1);
        wait_scl4(1'b1, ok);
        chk("t6_scl_rise", ok, 1);
        h = 0;
        while (scl4 && h < 100) begin
            h++;
            @(posedge clk);
            #1;
        end
        l = 0;
        while (!scl4 && l < 100) begin
            l++;
            @(posedge clk);
            #1;
        end
        chk("t6_high_len", h, 8);
        chk("t6_low_len", l, 8);
        wait_end(1'b1, n);
        chk("t6_end_cyc", n, 453);
        chk("t6_ack", ack4, 0);
        @(negedge clk) en4 = 1'b0;
        @(posedge clk);
        #1 chk("t6_end_drop", end4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
